oversampling_sensor_ctrl: RTL and testbench

//  Sequences one oversampling ISERDES + bit-detector sensor channel (600/150 MHz theremin front end).

---
 rtl/oversampling_sensor_ctrl.sv | 136 +++++++++++++
 tb/tb_oversampling_sensor_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/oversampling_sensor_ctrl.sv
// Start-up sequencer and edge-silence watchdog for one oversampling ISERDES sensor channel.
// Optional feature: define SENSOR_CTRL_AUTORESTART_EN to restart the datapath on a watchdog timeout.
module oversampling_sensor_ctrl #(
  parameter int RESET_CYCLES   = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int RESTART_W      = 8
) (
  input  logic                 CLK_PARALLEL,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 DLY_RDY,
  input  logic                 DET_FLAG,
  input  logic [5:0]           DET_BIT,
  output logic                 SERDES_RESET,
  output logic                 SERDES_CE,
  output logic                 READY,
  output logic                 SIGNAL_OK,
  output logic                 EVENT_VALID,
  output logic [5:0]           EVENT_BIT,
  output logic [RESTART_W-1:0] RESTART_COUNT,
  output logic [2:0]           DBG_STATE
);

  localparam int PHASE_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] HOLD_LOAD   = PW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LOAD = PW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_V   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_M1  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_RST_HOLD = 3'd2,
    S_SETTLE   = 3'd3,
`ifdef SENSOR_CTRL_AUTORESTART_EN
    S_RESTART  = 3'd5,
`endif
    S_RUN      = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rdy_meta;
  logic          rdy;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] silence;
  logic          timeout_hit;
  logic          live_nxt;

  assign DBG_STATE   = state;
  assign timeout_hit = !DET_FLAG && (silence >= TIMEOUT_M1);
  assign live_nxt    = (state_nxt == S_SETTLE) || (state_nxt == S_RUN);

  always_comb begin
    state_nxt = state;
    if (!ENABLE) begin
      state_nxt = S_IDLE;
    end else if (!rdy && (state == S_RST_HOLD || state == S_SETTLE || state == S_RUN)) begin
      state_nxt = S_WAIT_RDY;
    end else begin
      case (state)
        S_IDLE:     state_nxt = S_WAIT_RDY;
        S_WAIT_RDY: state_nxt = rdy ? S_RST_HOLD : S_WAIT_RDY;
        S_RST_HOLD: state_nxt = (phase_cnt == '0) ? S_SETTLE : S_RST_HOLD;
        S_SETTLE:   state_nxt = (phase_cnt == '0) ? S_RUN : S_SETTLE;
`ifdef SENSOR_CTRL_AUTORESTART_EN
        S_RUN:      state_nxt = timeout_hit ? S_RESTART : S_RUN;
        S_RESTART:  state_nxt = S_RST_HOLD;
`else
        S_RUN:      state_nxt = S_RUN;
`endif
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // EVENT_VALID is a one-cycle pulse with no back-pressure: the consumer must take
  // EVENT_BIT in the cycle EVENT_VALID=1; EVENT_BIT holds its value afterwards.
  always_ff @(posedge CLK_PARALLEL or posedge RESET) begin
    if (RESET) begin
      rdy_meta      <= 1'b0;
      rdy           <= 1'b0;
      state         <= S_IDLE;
      phase_cnt     <= '0;
      silence       <= '0;
      SERDES_RESET  <= 1'b1;
      SERDES_CE     <= 1'b0;
      READY         <= 1'b0;
      SIGNAL_OK     <= 1'b0;
      EVENT_VALID   <= 1'b0;
      EVENT_BIT     <= '0;
      RESTART_COUNT <= '0;
    end else begin
      rdy_meta     <= DLY_RDY;
      rdy          <= rdy_meta;
      state        <= state_nxt;
      SERDES_RESET <= !live_nxt;
      SERDES_CE    <= live_nxt;
      READY        <= (state_nxt == S_RUN);
      EVENT_VALID  <= 1'b0;

      if (state_nxt == S_RST_HOLD && state != S_RST_HOLD) begin
        phase_cnt <= HOLD_LOAD;
      end else if (state_nxt == S_SETTLE && state != S_SETTLE) begin
        phase_cnt <= SETTLE_LOAD;
      end else if (phase_cnt != '0) begin
        phase_cnt <= phase_cnt - PW'(1);
      end

      // A detector event in the cycle the watchdog would expire takes precedence.
      if (state == S_RUN && state_nxt == S_RUN) begin
        if (DET_FLAG) begin
          EVENT_VALID <= 1'b1;
          EVENT_BIT   <= DET_BIT;
          silence     <= '0;
          SIGNAL_OK   <= 1'b1;
        end else begin
          if (silence != TIMEOUT_V) silence <= silence + TW'(1);
          if (timeout_hit) SIGNAL_OK <= 1'b0;
        end
      end else begin
        SIGNAL_OK <= 1'b0;
        if (state_nxt == S_RUN) silence <= '0;
      end

`ifdef SENSOR_CTRL_AUTORESTART_EN
      if (state_nxt == S_RESTART && state != S_RESTART && RESTART_COUNT != {RESTART_W{1'b1}})
        RESTART_COUNT <= RESTART_COUNT + RESTART_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_oversampling_sensor_ctrl.sv
// Bench for oversampling_sensor_ctrl: directed start-up/watchdog/reset scenarios plus random
// traffic, all compared every cycle against a phase/timer reference model.
module tb_oversampling_sensor_ctrl;

  localparam int RC = 4;
  localparam int SC = 3;
  localparam int TO = 20;
  localparam int RW = 2;
`ifdef SENSOR_CTRL_AUTORESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int P_IDLE = 0, P_WAIT = 1, P_HOLD = 2, P_SETTLE = 3, P_RUN = 4, P_RESTART = 5;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic          enable, dly_rdy, det_flag;
  logic [5:0]    det_bit;
  logic          serdes_reset, serdes_ce, ready, signal_ok, event_valid;
  logic [5:0]    event_bit;
  logic [RW-1:0] restart_count;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  oversampling_sensor_ctrl #(
    .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .RESTART_W(RW)
  ) dut (
    .CLK_PARALLEL(clk), .RESET(rst), .ENABLE(enable), .DLY_RDY(dly_rdy),
    .DET_FLAG(det_flag), .DET_BIT(det_bit),
    .SERDES_RESET(serdes_reset), .SERDES_CE(serdes_ce), .READY(ready),
    .SIGNAL_OK(signal_ok), .EVENT_VALID(event_valid), .EVENT_BIT(event_bit),
    .RESTART_COUNT(restart_count), .DBG_STATE(dbg_state)
  );

  // scoreboard counters
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: phase + remaining-cycle timer + quiet-time counter
  int         m_ph, m_left, m_quiet, m_restarts;
  bit         m_ok, m_ev_v, m_r1, m_r2;
  logic [5:0] m_ev_b;

  function automatic void model_reset();
    m_ph = P_IDLE; m_left = 0; m_quiet = 0; m_restarts = 0;
    m_ok = 0; m_ev_v = 0; m_r1 = 0; m_r2 = 0; m_ev_b = '0;
  endfunction

  function automatic void model_step(input bit en, input bit pin, input bit flag, input logic [5:0] b);
    bit rdy_seen;
    int prev;
    rdy_seen = m_r2;
    m_r2 = m_r1;
    m_r1 = pin;
    prev = m_ph;
    m_ev_v = 0;
    if (!en) m_ph = P_IDLE;
    else if (!rdy_seen && (prev == P_HOLD || prev == P_SETTLE || prev == P_RUN)) m_ph = P_WAIT;
    else begin
      case (prev)
        P_IDLE: m_ph = P_WAIT;
        P_WAIT: if (rdy_seen) begin m_ph = P_HOLD; m_left = RC; end
        P_HOLD: begin
          m_left--;
          if (m_left == 0) begin m_ph = P_SETTLE; m_left = SC; end
        end
        P_SETTLE: begin
          m_left--;
          if (m_left == 0) begin m_ph = P_RUN; m_quiet = 0; end
        end
        P_RUN: begin
          if (flag) begin
            m_quiet = 0; m_ok = 1; m_ev_v = 1; m_ev_b = b;
          end else begin
            if (m_quiet < TO) m_quiet++;
            if (m_quiet >= TO) begin
              m_ok = 0;
              if (AUTO) begin
                m_ph = P_RESTART;
                m_restarts = (m_restarts + 1 > 3) ? 3 : m_restarts + 1;
              end
            end
          end
        end
        P_RESTART: begin m_ph = P_HOLD; m_left = RC; end
        default: m_ph = P_IDLE;
      endcase
    end
    if (m_ph != P_RUN) begin m_ok = 0; m_ev_v = 0; end
  endfunction

  task automatic check_all();
    bit live;
    live = (m_ph == P_SETTLE) || (m_ph == P_RUN);
    check("serdes_reset", serdes_reset, !live);
    check("serdes_ce", serdes_ce, live);
    check("ready", ready, m_ph == P_RUN);
    check("signal_ok", signal_ok, m_ok);
    check("event_valid", event_valid, m_ev_v);
    check("event_bit", event_bit, m_ev_b);
    check("restart_count", restart_count, m_restarts);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_sres"}, serdes_reset, 1);
    check({p, "_ce"}, serdes_ce, 0);
    check({p, "_ready"}, ready, 0);
    check({p, "_ok"}, signal_ok, 0);
    check({p, "_ev"}, event_valid, 0);
    check({p, "_bit"}, event_bit, 0);
    check({p, "_rcnt"}, restart_count, 0);
  endtask

  // driver: apply inputs just after an edge, advance model, sample 1 ns after the next edge
  task automatic tick(input bit en, input bit pin, input bit flag, input logic [5:0] b);
    enable = en; dly_rdy = pin; det_flag = flag; det_bit = b;
    model_step(en, pin, flag, b);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_to_ready(input int budget);
    for (int i = 0; i < budget && !ready; i++) tick(1, 1, 0, 6'd0);
    check("reach_ready", ready, 1);
  endtask

  int sres_fall, ready_rise, settle_ev, pulse_len, max_pulse, sres_seen;
  int density;

  initial begin
    rst = 1'b1; enable = 0; dly_rdy = 0; det_flag = 0; det_bit = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;

    // start-up: DLY_RDY high from cycle 10, detector chatter during settle
    sres_fall = 0; ready_rise = 0; settle_ev = 0;
    for (int k = 1; k <= 19; k++) begin
      tick(1, k >= 10, k >= 17, 6'(k));
      if (!serdes_reset && sres_fall == 0) sres_fall = k;
      if (ready && ready_rise == 0) ready_rise = k;
      if (event_valid) settle_ev++;
    end
    check("sres_fall_cycle", sres_fall, 16);
    check("ready_rise_cycle", ready_rise, 19);
    check("settle_events", settle_ev, 0);

    tick(1, 1, 1, 6'd37);
    check("ev37_valid", event_valid, 1);
    check("ev37_bit", event_bit, 37);
    check("ev37_ok", signal_ok, 1);

    // silence watchdog boundary
    repeat (19) tick(1, 1, 0, 6'd0);
    check("ok_after_19_idle", signal_ok, 1);
    tick(1, 1, 0, 6'd0);
    check("ok_after_20_idle", signal_ok, 0);
    run_to_ready(40);
    tick(1, 1, 1, 6'd5);
    repeat (19) tick(1, 1, 0, 6'd0);
    tick(1, 1, 1, 6'd9);
    check("ok_event_on_20th", signal_ok, 1);
    tick(1, 1, 0, 6'd0);
    check("ok_hold", signal_ok, 1);

    // repeated timeouts
    max_pulse = 0; pulse_len = 0;
    repeat (150) begin
      tick(1, 1, 0, 6'd0);
      pulse_len = serdes_reset ? pulse_len + 1 : 0;
      if (pulse_len > max_pulse) max_pulse = pulse_len;
    end
    check("restart_pulse_len", max_pulse, AUTO ? 5 : 0);
    check("restart_saturated", restart_count, AUTO ? 3 : 0);

    // DLY_RDY loss in RUN, then disable while not ready
    run_to_ready(60);
    sres_seen = 0;
    for (int i = 1; i <= 3; i++) begin
      tick(1, 0, 0, 6'd0);
      if (serdes_reset && sres_seen == 0) sres_seen = i;
    end
    check("rdy_drop_sres_cycle", sres_seen, 3);
    check("rdy_drop_ready", ready, 0);
    tick(0, 0, 0, 6'd0);
    check("disable_ready", ready, 0);
    check("disable_sres", serdes_reset, 1);
    repeat (4) tick(1, 1, 0, 6'd0);
    run_to_ready(60);

    // random traffic with varying event density
    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(0, 4))
        0: density = 0;
        1: density = 2;
        2: density = 8;
        3: density = 40;
        default: density = 80;
      endcase
      repeat (200) begin
        tick($urandom_range(0, 199) != 0, $urandom_range(0, 299) != 0,
             $urandom_range(0, 99) < density, 6'($urandom));
      end
    end

    // async reset mid-RUN, off the clock edge
    run_to_ready(60);
    #3 rst = 1'b1;
    #1;
    check_reset_vals("arst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run_to_ready(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
